grid_scan_painter: RTL and testbench
====================================

// Module: grid_scan_painter
// PURPOSE
//  Parametrised cell sequencer driving the grid renderer (vga_main) position/colour inputs.
//  Walks the GRID_DIM x GRID_DIM board one cell per DWELL cycles and emits a position code plus a colour.
//  Mode-selected colouring: clear, snapshot-show, live echo, evaluate against snapshot.
//  Adds start/busy/done handshake, abort, loop mode and mismatch count for the game controller.
// PARAMETERS
//  GRID_DIM   3             cells per row/column; CELLS = GRID_DIM*GRID_DIM
//  DWELL      1000          CLOCK_50 cycles per cell (>=1)
//  COLOR_W    9             colour width
//  COLOR_ON   9'b000_111_000  lit/correct colour
//  COLOR_OFF  9'b111_111_111  unlit colour
//  COLOR_BAD  9'b111_000_000  mismatch colour
//  (derived) CW = $clog2(GRID_DIM+1); MW = $clog2(CELLS+1)
// PORTS
//  CLOCK_50        in   1       system clock
//  reset           in   1       asynchronous, active-low reset
//  start           in   1       1-cycle request; samples mode/loop
//  mode            in   2       00 CLEAR, 01 SHOW, 10 EVAL, 11 LIVE
//  loop            in   1       1 = repeat scan until stop/start
//  stop            in   1       abort scan, return idle
//  board           in   CELLS   board bits, bit k = cell k (row-major)
//  busy            out  1       scan in progress
//  done            out  1       1-cycle pulse, pass completed
//  paint_valid     out  1       1-cycle pulse, position/color just updated
//  position        out  2*CW    {GRID_DIM-row, GRID_DIM-col} of painted cell
//  color           out  COLOR_W colour for position
//  snapshot        out  CELLS   board captured by last SHOW start
//  mismatch_count  out  MW      EVAL cells where board != snapshot, current pass
// BEHAVIOUR
//  Reset (reset=0, async): busy=0, done=0, paint_valid=0, position=code(cell 0), color=COLOR_OFF,
//   snapshot=0, mismatch_count=0, FSM=IDLE, cell index=0, dwell counter=0.
//  FSM: IDLE -> SCAN on start; SCAN -> IDLE after cell CELLS-1 (loop=0) or on stop; SCAN -> SCAN wraps (loop=1).
//  start accepted at edge E0: busy=1 from E0; mode/loop latched; cell=0; dwell=0; mismatch_count=0;
//   if mode==SHOW, snapshot<=board at E0.
//  Dwell counts 0..DWELL-1; cell k painted at edge E0+(k+1)*DWELL: position, color, paint_valid=1
//   registered together; paint_valid low otherwise. DWELL=1 -> paint every cycle.
//  Position code: row r=k/GRID_DIM, col c=k%GRID_DIM; position={(GRID_DIM-r)[CW-1:0],(GRID_DIM-c)[CW-1:0]}.
//   GRID_DIM=3: cells 0..8 -> 1111,1110,1101,1011,1010,1001,0111,0110,0101.
//  Colour per latched mode, board sampled at paint edge:
//   CLEAR: COLOR_OFF. SHOW: snapshot[k]?ON:OFF. LIVE: board[k]?ON:OFF.
//   EVAL: board&snap->ON; board^snap->BAD (mismatch_count+1, saturates at CELLS); neither->OFF.
//  Last cell (k=CELLS-1): done=1 same cycle as its paint_valid. loop=0: busy=0 at that edge.
//   loop=1: busy stays 1, cell wraps to 0, mismatch_count cleared at next pass's cell-0 paint.
//  Outputs hold last painted value while IDLE.
//  stop while busy: IDLE at next edge, busy=0, no done, no paint. stop while idle: ignored.
//  start while busy: abort, restart from cell 0 with new mode; no done for aborted pass.
//  start and stop same cycle: start wins.
//  mismatch_count meaningful only for EVAL; stays 0 in other modes.
// TESTING
//  1 DWELL=4, start mode=LIVE board=9'h1FF -> 9 paint_valid pulses 4 cycles apart, positions 1111..0101,
//    all COLOR_ON; done with 9th pulse; busy falls same edge.
//  2 SHOW board=9'b000010001, then board=0 mid-scan -> colours follow snapshot 9'h011
//    (cells 0,4 ON, rest OFF); snapshot output=9'h011.
//  3 After 2, EVAL board=9'b100010000 -> cell0 BAD, cell4 ON, cell8 BAD, others OFF; mismatch_count=2 at done.
//  4 loop=1 CLEAR -> done pulses every 9*DWELL cycles, busy stays 1; stop mid-pass -> busy 0 next edge,
//    no further paint/done.
//  5 start LIVE, at cell 3 assert start mode=CLEAR -> next paint is cell 0 (1111, COLOR_OFF);
//    no done for aborted pass.
//  6 Drop reset mid-scan (async, no clock edge) -> all outputs at reset values immediately;
//    DWELL=1 run paints 9 consecutive cycles.

Source files
------------

// File: rtl/grid_scan_painter.sv
// grid_scan_painter: walks the board one cell per DWELL clocks and
// drives position/colour for the grid renderer.
module grid_scan_painter #(
  parameter int GRID_DIM = 3,
  parameter int DWELL = 1000,
  parameter int COLOR_W = 9,
  parameter logic [COLOR_W-1:0] COLOR_ON = 9'b000_111_000,
  parameter logic [COLOR_W-1:0] COLOR_OFF = 9'b111_111_111,
  parameter logic [COLOR_W-1:0] COLOR_BAD = 9'b111_000_000,
  localparam int CELLS = GRID_DIM * GRID_DIM,
  localparam int CW = $clog2(GRID_DIM + 1),
  localparam int MW = $clog2(CELLS + 1)
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic               loop,
  input  logic               stop,
  input  logic [CELLS-1:0]   board,
  output logic               busy,
  output logic               done,
  output logic               paint_valid,
  output logic [2*CW-1:0]    position,
  output logic [COLOR_W-1:0] color,
  output logic [CELLS-1:0]   snapshot,
  output logic [MW-1:0]      mismatch_count
);

  localparam int KW = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] DIM = CW'(GRID_DIM);
  localparam logic [2*CW-1:0] POS0 = {DIM, DIM};

  localparam logic [1:0] M_CLEAR = 2'b00;
  localparam logic [1:0] M_SHOW = 2'b01;
  localparam logic [1:0] M_EVAL = 2'b10;
  localparam logic [1:0] M_LIVE = 2'b11;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t state_q, state_d;
  logic [1:0] mode_q;
  logic loop_q;
  logic [KW-1:0] cell_q;
  logic [CW-1:0] row_q, col_q;
  logic [DCW-1:0] dwell_q;
  logic load, halt, paint, last;
  logic bit_b, bit_s, bad;
  logic [COLOR_W-1:0] color_d;
  logic [MW-1:0] mm_base, mm_d;

  assign busy = (state_q == SCAN);
  assign last = (cell_q == KW'(CELLS - 1));
  assign bit_b = board[cell_q];
  assign bit_s = snapshot[cell_q];

  // State register
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  end

  // Next state and strobes: start beats stop, stop beats paint
  always_comb begin
    state_d = state_q;
    load = 1'b0;
    halt = 1'b0;
    paint = 1'b0;
    if (start) begin
      load = 1'b1;
      state_d = SCAN;
    end else if (state_q == SCAN) begin
      if (stop) begin
        halt = 1'b1;
        state_d = IDLE;
      end else if (dwell_q == DCW'(DWELL - 1)) begin
        paint = 1'b1;
        if (last && !loop_q) state_d = IDLE;
      end
    end
  end

  // Colour of the current cell and the running mismatch tally
  always_comb begin
    color_d = COLOR_OFF;
    bad = 1'b0;
    unique case (mode_q)
      M_CLEAR: color_d = COLOR_OFF;
      M_SHOW: color_d = bit_s ? COLOR_ON : COLOR_OFF;
      M_LIVE: color_d = bit_b ? COLOR_ON : COLOR_OFF;
      M_EVAL: begin
        if (bit_b && bit_s) begin
          color_d = COLOR_ON;
        end else if (bit_b ^ bit_s) begin
          color_d = COLOR_BAD;
          bad = 1'b1;
        end
      end
    endcase
    mm_base = (cell_q == '0) ? '0 : mismatch_count;
    mm_d = mm_base;
    if (bad && mm_base != MW'(CELLS)) mm_d = mm_base + MW'(1);
  end

  // Scan datapath: dwell timer, cell walk and registered paint outputs
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      mode_q <= M_CLEAR;
      loop_q <= 1'b0;
      cell_q <= '0;
      row_q <= '0;
      col_q <= '0;
      dwell_q <= '0;
      done <= 1'b0;
      paint_valid <= 1'b0;
      position <= POS0;
      color <= COLOR_OFF;
      snapshot <= '0;
      mismatch_count <= '0;
    end else begin
      paint_valid <= paint;
      done <= paint && last;
      if (load) begin
        mode_q <= mode;
        loop_q <= loop;
        cell_q <= '0;
        row_q <= '0;
        col_q <= '0;
        dwell_q <= '0;
        mismatch_count <= '0;
        if (mode == M_SHOW) snapshot <= board;
      end else if (busy && !halt) begin
        if (paint) begin
          dwell_q <= '0;
          position <= {DIM - row_q, DIM - col_q};
          color <= color_d;
          mismatch_count <= mm_d;
          if (last) begin
            cell_q <= '0;
            row_q <= '0;
            col_q <= '0;
          end else begin
            cell_q <= cell_q + KW'(1);
            if (col_q == CW'(GRID_DIM - 1)) begin
              col_q <= '0;
              row_q <= row_q + CW'(1);
            end else begin
              col_q <= col_q + CW'(1);
            end
          end
        end else begin
          dwell_q <= dwell_q + DCW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_grid_scan_painter.sv
// tb_grid_scan_painter: directed checks of scan timing, colouring,
// loop/abort/stop handling and async reset.
module tb_grid_scan_painter;

  localparam logic [8:0] ON = 9'h038;
  localparam logic [8:0] OFF = 9'h1FF;
  localparam logic [8:0] BAD = 9'h1C0;
  localparam logic [1:0] CLEAR = 2'b00;
  localparam logic [1:0] SHOW = 2'b01;
  localparam logic [1:0] EVAL = 2'b10;
  localparam logic [1:0] LIVE = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start1 = 1'b0;
  logic [1:0] mode = 2'b00;
  logic loop = 1'b0;
  logic stop = 1'b0;
  logic [8:0] board = '0;

  logic busy, done, paint_valid;
  logic [3:0] position;
  logic [8:0] color, snapshot;
  logic [3:0] mismatch_count;

  logic busy1, done1, pv1;
  logic [3:0] pos1;
  logic [8:0] col1, snap1;
  logic [3:0] mm1;

  int tests = 0;
  int fails = 0;

  logic [3:0] pos_exp [9] = '{4'hF, 4'hE, 4'hD, 4'hB, 4'hA,
                              4'h9, 4'h7, 4'h6, 4'h5};

  always #5 clk = ~clk;

  grid_scan_painter #(.DWELL(4)) u0 (
    .CLOCK_50(clk), .reset(rst_n), .start(start), .mode(mode),
    .loop(loop), .stop(stop), .board(board), .busy(busy),
    .done(done), .paint_valid(paint_valid), .position(position),
    .color(color), .snapshot(snapshot),
    .mismatch_count(mismatch_count)
  );

  grid_scan_painter #(.DWELL(1)) u1 (
    .CLOCK_50(clk), .reset(rst_n), .start(start1), .mode(mode),
    .loop(1'b0), .stop(1'b0), .board(board), .busy(busy1),
    .done(done1), .paint_valid(pv1), .position(pos1),
    .color(col1), .snapshot(snap1), .mismatch_count(mm1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [1:0] m, input logic lp);
    mode = m;
    loop = lp;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic scan_check(input string tag, input int n,
                            input logic [8:0] on_m,
                            input logic [8:0] bad_m,
                            input logic stay_busy);
    int gap;
    logic [8:0] ce;
    for (int k = 0; k < n; k++) begin
      gap = 0;
      do begin
        tick();
        gap++;
      end while (!paint_valid && gap < 40);
      ce = bad_m[k] ? BAD : (on_m[k] ? ON : OFF);
      chk({tag, " gap"}, gap, 4);
      chk({tag, " pos"}, position, pos_exp[k]);
      chk({tag, " color"}, color, ce);
      chk({tag, " done"}, done, (k == 8));
      chk({tag, " busy"}, busy, (k < 8) || stay_busy);
    end
  endtask

  initial begin
    int pulses;
    tick();
    tick();
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst pv", paint_valid, 0);
    chk("rst pos", position, 4'hF);
    chk("rst color", color, OFF);
    chk("rst snap", snapshot, 0);
    chk("rst mm", mismatch_count, 0);
    rst_n = 1'b1;
    tick();

    board = 9'h1FF;
    go(LIVE, 1'b0);
    chk("t1 busy", busy, 1);
    chk("t1 pv", paint_valid, 0);
    scan_check("t1", 9, 9'h1FF, 9'h000, 1'b0);
    chk("t1 mm", mismatch_count, 0);

    board = 9'h011;
    go(SHOW, 1'b0);
    chk("t2 snap", snapshot, 9'h011);
    board = 9'h000;
    scan_check("t2", 9, 9'h011, 9'h000, 1'b0);

    board = 9'h110;
    go(EVAL, 1'b0);
    scan_check("t3", 9, 9'h010, 9'h101, 1'b0);
    chk("t3 mm", mismatch_count, 2);

    board = 9'h112;
    go(EVAL, 1'b0);
    scan_check("t6a", 2, 9'h000, 9'h003, 1'b0);
    chk("t6a mm", mismatch_count, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 busy", busy, 0);
    chk("t6 done", done, 0);
    chk("t6 pv", paint_valid, 0);
    chk("t6 pos", position, 4'hF);
    chk("t6 color", color, OFF);
    chk("t6 snap", snapshot, 0);
    chk("t6 mm", mismatch_count, 0);
    #2 rst_n = 1'b1;
    tick();

    board = 9'h0F0;
    go(CLEAR, 1'b1);
    scan_check("t4p1", 9, 9'h000, 9'h000, 1'b1);
    scan_check("t4p2", 9, 9'h000, 9'h000, 1'b1);
    for (int i = 0; i < 6; i++) tick();
    loop = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t4 stop busy", busy, 0);
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (paint_valid || done) pulses++;
    end
    chk("t4 after stop", pulses, 0);

    board = 9'h1FF;
    go(LIVE, 1'b0);
    scan_check("t5a", 4, 9'h1FF, 9'h000, 1'b0);
    go(CLEAR, 1'b0);
    scan_check("t5b", 9, 9'h000, 9'h000, 1'b0);

    start1 = 1'b1;
    mode = LIVE;
    tick();
    start1 = 1'b0;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("d1 pv", pv1, 1);
      chk("d1 pos", pos1, pos_exp[k]);
      chk("d1 color", col1, ON);
      chk("d1 done", done1, (k == 8));
    end
    tick();
    chk("d1 idle pv", pv1, 0);
    chk("d1 idle busy", busy1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
